// File: rtl/ring_freq_meter_if.sv
// Control/result bundle of the ring-oscillator frequency meter.
// master = firmware side, slave = meter.
interface ring_freq_meter_if #(
    parameter int GATE_W = 16,
    parameter int CNT_W  = 16
);
    logic              start;
    logic [GATE_W-1:0] gate_cycles;
    logic              abort;
    logic              busy;
    logic [CNT_W-1:0]  result;
    logic              result_valid;
    logic              result_ready;
    logic              overflow;

    modport master (
        output start, gate_cycles, abort, result_ready,
        input  busy, result, result_valid, overflow
    );

    modport slave (
        input  start, gate_cycles, abort, result_ready,
        output busy, result, result_valid, overflow
    );
endinterface

// File: rtl/ring_freq_meter.sv
// Gated frequency counter: synchronises the ring oscillator into clk and
// counts its rising edges over a programmable window of clk cycles.
module ring_freq_meter #(
    parameter int GATE_W      = 16,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_osc_in,
    ring_freq_meter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ARM, GATE, DONE} state_t;

    localparam int ARM_W = $clog2(SYNC_STAGES + 1) + 1;

    state_t              r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                r_hist;
    logic [ARM_W-1:0]    r_arm;
    logic [GATE_W-1:0]   r_win;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_ovf_win;
    logic [CNT_W-1:0]    r_result;
    logic                r_valid;
    logic                r_ovf;
    logic                r_busy;

    logic                w_rise;
    logic                w_inc;
    logic                w_cnt_max;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic                w_ovf_nxt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_osc_in};
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_rise    = r_sync[SYNC_STAGES-1] & ~r_hist;
    assign w_inc     = (r_state == GATE) && w_rise;
    assign w_cnt_max = &r_cnt;
    assign w_cnt_nxt = (w_inc && !w_cnt_max) ? r_cnt + 1'b1 : r_cnt;
    assign w_ovf_nxt = r_ovf_win | (w_inc & w_cnt_max);

    // ARM runs SYNC_STAGES+1 cycles so the history flop is also refilled
    // with post-acceptance samples before the first counted edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_arm     <= '0;
            r_win     <= '0;
            r_cnt     <= '0;
            r_ovf_win <= 1'b0;
            r_result  <= '0;
            r_valid   <= 1'b0;
            r_ovf     <= 1'b0;
            r_busy    <= 1'b0;
        end else if (bus.abort) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_win     <= bus.gate_cycles;
                        r_cnt     <= '0;
                        r_ovf_win <= 1'b0;
                        r_ovf     <= 1'b0;
                        r_arm     <= '0;
                        r_busy    <= 1'b1;
                        if (bus.gate_cycles == '0) begin
                            r_state  <= DONE;
                            r_result <= '0;
                            r_valid  <= 1'b1;
                        end else begin
                            r_state <= ARM;
                        end
                    end
                end
                ARM: begin
                    r_arm <= r_arm + 1'b1;
                    if (r_arm == ARM_W'(SYNC_STAGES))
                        r_state <= GATE;
                end
                GATE: begin
                    r_cnt     <= w_cnt_nxt;
                    r_ovf_win <= w_ovf_nxt;
                    if (r_win == GATE_W'(1)) begin
                        r_state  <= DONE;
                        r_result <= w_cnt_nxt;
                        r_ovf    <= w_ovf_nxt;
                        r_valid  <= 1'b1;
                    end else begin
                        r_win <= r_win - 1'b1;
                    end
                end
                DONE: begin
                    if (bus.result_ready) begin
                        r_state <= IDLE;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy         = r_busy;
    assign bus.result       = r_result;
    assign bus.result_valid = r_valid;
    assign bus.overflow     = r_ovf;
endmodule

// File: tb/tb_ring_freq_meter.sv
// Bench for ring_freq_meter: a 16-bit and a 4-bit counter build share the
// same stimulus; expectations come from counting logged oscillator samples.
module tb_ring_freq_meter;
    localparam int S   = 2;
    localparam int GW  = 16;
    localparam int CW  = 16;
    localparam int CWS = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          osc;
    logic          start, abort, ready;
    logic [GW-1:0] gate;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    bit samp [0:49999];

    int osc_mode = 0;
    int osc_per  = 4;
    int ph       = 0;

    int prev_a;
    int obs_a, obs_b, obs_ovf_b;

    always #5 clk = ~clk;

    ring_freq_meter_if #(.GATE_W(GW), .CNT_W(CW))  bus_a ();
    ring_freq_meter_if #(.GATE_W(GW), .CNT_W(CWS)) bus_b ();

    assign bus_a.start = start;  assign bus_a.gate_cycles = gate;
    assign bus_a.abort = abort;  assign bus_a.result_ready = ready;
    assign bus_b.start = start;  assign bus_b.gate_cycles = gate;
    assign bus_b.abort = abort;  assign bus_b.result_ready = ready;

    ring_freq_meter #(.GATE_W(GW), .CNT_W(CW), .SYNC_STAGES(S)) u_dut_a (
        .i_clk(clk), .i_rst(rst), .i_osc_in(osc), .bus(bus_a));
    ring_freq_meter #(.GATE_W(GW), .CNT_W(CWS), .SYNC_STAGES(S)) u_dut_b (
        .i_clk(clk), .i_rst(rst), .i_osc_in(osc), .bus(bus_b));

    always @(negedge clk) begin
        case (osc_mode)
            0:       osc = 1'b0;
            1:       osc = 1'b1;
            2:       osc = ((ph % osc_per) < (osc_per / 2)) ? 1'b1 : 1'b0;
            default: osc = 1'($urandom_range(0, 1));
        endcase
        ph++;
    end

    always @(posedge clk) begin
        samp[cyc] <= osc;
        cyc       <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Rising transitions in the clk-sampled oscillator over G sample
    // intervals, starting with the first sample taken after acceptance.
    function automatic int model_edges(input int t, input int g);
        int n = 0;
        for (int i = t + 2; i <= t + 1 + g; i++)
            if (samp[i] && !samp[i-1]) n++;
        return n;
    endfunction

    task automatic measure(input int g, input int hold, input string tag);
        int t, lat, n, ea, eb, p, r0;
        bit busy_ok, stable;
        @(negedge clk);
        start = 1'b1;
        gate  = GW'(g);
        @(posedge clk); #1;
        t     = cyc - 1;
        start = 1'b0;
        gate  = GW'($urandom);
        lat     = -1;
        busy_ok = 1'b1;
        for (int k = 0; k < g + S + 20; k++) begin
            if (bus_a.result_valid) begin
                lat = cyc - 1 - t;
                break;
            end
            if (!bus_a.busy) busy_ok = 1'b0;
            @(posedge clk); #1;
        end
        chk({tag, "_latency"}, lat, (g == 0) ? 0 : S + g + 1);
        chk({tag, "_busy"}, 32'(busy_ok), 1);
        n  = model_edges(t, g);
        ea = (n > (1 << CW) - 1)  ? (1 << CW) - 1  : n;
        eb = (n > (1 << CWS) - 1) ? (1 << CWS) - 1 : n;
        obs_a     = int'(bus_a.result);
        obs_b     = int'(bus_b.result);
        obs_ovf_b = int'(bus_b.overflow);
        chk({tag, "_res_a"}, 32'(bus_a.result), ea);
        chk({tag, "_ovf_a"}, 32'(bus_a.overflow), (n > (1 << CW) - 1) ? 1 : 0);
        chk({tag, "_res_b"}, 32'(bus_b.result), eb);
        chk({tag, "_ovf_b"}, 32'(bus_b.overflow), (n > (1 << CWS) - 1) ? 1 : 0);
        chk({tag, "_vld_b"}, 32'(bus_b.result_valid), 1);
        stable = 1'b1;
        r0     = int'(bus_a.result);
        p      = (hold > 0) ? int'($urandom_range(0, hold - 1)) : 0;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            start = (k == p);
            gate  = 16'd3;
            @(posedge clk); #1;
            start = 1'b0;
            if (int'(bus_a.result) != r0 || !bus_a.result_valid || !bus_a.busy) stable = 1'b0;
        end
        if (hold > 0) chk({tag, "_hold"}, 32'(stable), 1);
        @(negedge clk);
        start = 1'b1;
        gate  = 16'd5;
        ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ready = 1'b0;
        chk({tag, "_hs_vld"}, 32'(bus_a.result_valid), 0);
        chk({tag, "_hs_busy"}, 32'(bus_a.busy), 0);
        chk({tag, "_hs_res"}, 32'(bus_a.result), ea);
        prev_a = ea;
    endtask

    initial begin
        int t_dummy;
        bit seen;
        rst = 1'b1; start = 1'b0; abort = 1'b0; ready = 1'b0; gate = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus_a.busy), 0);
        chk("rst_res",  32'(bus_a.result), 0);
        chk("rst_vld",  32'(bus_a.result_valid), 0);
        chk("rst_ovf",  32'(bus_a.overflow), 0);
        @(negedge clk); rst = 1'b0;
        repeat (4) @(negedge clk);

        osc_mode = 2; osc_per = 4;
        measure(100, 20, "sq4");
        chk("sq4_const_a", 32'(obs_a), 25);
        chk("sq4_const_b", 32'(obs_b), 15);
        chk("sq4_const_ovf_b", 32'(obs_ovf_b), 1);

        osc_mode = 0;
        repeat (5) @(negedge clk);
        measure(50, 2, "low");
        chk("low_const", 32'(obs_a), 0);
        osc_mode = 1;
        repeat (5) @(negedge clk);
        measure(50, 0, "high");
        chk("high_const", 32'(obs_a), 0);

        osc_mode = 3;
        measure(0, 3, "zero");

        // abort mid-window, with a simultaneous start that must lose
        measure(30, 0, "pre_abort");
        @(negedge clk); start = 1'b1; gate = 16'd200;
        @(posedge clk); #1; start = 1'b0;
        repeat (50) @(posedge clk);
        @(negedge clk); abort = 1'b1; start = 1'b1;
        @(posedge clk); #1; abort = 1'b0; start = 1'b0;
        chk("abort_busy", 32'(bus_a.busy), 0);
        chk("abort_vld",  32'(bus_a.result_valid), 0);
        chk("abort_ovf",  32'(bus_b.overflow), 0);
        chk("abort_res",  32'(bus_a.result), prev_a);
        seen = 1'b0;
        for (int k = 0; k < 250; k++) begin
            @(posedge clk); #1;
            if (bus_a.result_valid || bus_a.busy) seen = 1'b1;
        end
        chk("abort_quiet", 32'(seen), 0);

        // reset mid-window
        @(negedge clk); start = 1'b1; gate = 16'd300;
        @(posedge clk); #1; start = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        #1;
        chk("mrst_busy", 32'(bus_a.busy), 0);
        chk("mrst_res",  32'(bus_a.result), 0);
        chk("mrst_vld",  32'(bus_a.result_valid), 0);
        chk("mrst_ovf",  32'(bus_b.overflow), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        osc_mode = 2; osc_per = 2;
        repeat (3) @(negedge clk);
        measure(8, 1, "per2");
        chk("per2_const", 32'(obs_a), 4);

        for (int it = 0; it < 10; it++) begin
            osc_mode = int'($urandom_range(2, 3));
            osc_per  = int'($urandom_range(2, 9));
            t_dummy  = int'($urandom_range(0, 3));
            repeat (t_dummy) @(negedge clk);
            measure(int'($urandom_range(1, 300)), int'($urandom_range(0, 4)), "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
